// File: rtl/uart_tx_fifo.sv
// Buffered 8-bit RS232 transmitter: byte FIFO feeding a start/data/stop serialiser at OVERSAMPLE clocks per bit.
// Optional parity bit (even/odd, chosen per frame) when UART_TX_PARITY_EN is defined.
module uart_tx_fifo #(
  parameter int DEPTH      = 16,
  parameter int AW         = 4,
  parameter int OVERSAMPLE = 16
) (
  input  logic          iSClk,
  input  logic          iRst,
  input  logic [7:0]    iData,
  input  logic          iPush,
  input  logic          iStopBits,
  input  logic          iClrOvf,
`ifdef UART_TX_PARITY_EN
  input  logic          iParityOdd,
`endif
  output logic          oTX,
  output logic          oFull,
  output logic          oEmpty,
  output logic [AW:0]   oCount,
  output logic          oBusy,
  output logic          oDone,
  output logic          oOverflow
);

  localparam int OSW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [OSW-1:0] OS_LAST  = OSW'(OVERSAMPLE - 1);
  localparam logic [OSW-1:0] OS_ONE   = OSW'(1);
  localparam logic [AW:0]    CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]    CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0]  PTR_ONE  = AW'(1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP1,
    STOP2
  } state_t;

  logic [7:0]     mem [DEPTH];
  logic [AW-1:0]  wrPtr;
  logic [AW-1:0]  rdPtr;
  logic [AW:0]    countNext;
  logic [7:0]     headByte;
  state_t         state;
  logic [OSW-1:0] osCnt;
  logic [2:0]     bitCnt;
  logic [7:0]     shiftReg;
  logic           stop2;
`ifdef UART_TX_PARITY_EN
  logic           parBit;
`endif
  logic           pushOk;
  logic           osEnd;
  logic           frameEnd;
  logic           pop;

  // Push handshake: iPush is the valid, ~oFull the ready; a byte transfers on any
  // edge where both are high, and a push seen while full is dropped and flagged.
  assign pushOk   = iPush & ~oFull;
  assign osEnd    = (osCnt == OS_LAST);
  assign frameEnd = osEnd && (((state == STOP1) && !stop2) || (state == STOP2));
  assign pop      = ~oEmpty && ((state == IDLE) || frameEnd);
  assign headByte = mem[rdPtr];

  always_comb begin
    countNext = oCount;
    if (pushOk && !pop) countNext = oCount + CNT_ONE;
    else if (!pushOk && pop) countNext = oCount - CNT_ONE;
  end

  always_ff @(posedge iSClk) begin
    if (pushOk) mem[wrPtr] <= iData;
  end

  always_ff @(posedge iSClk or posedge iRst) begin
    if (iRst) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      oCount    <= '0;
      oEmpty    <= 1'b1;
      oFull     <= 1'b0;
      oOverflow <= 1'b0;
    end else begin
      if (pushOk) wrPtr <= wrPtr + PTR_ONE;
      if (pop)    rdPtr <= rdPtr + PTR_ONE;
      oCount <= countNext;
      oEmpty <= (countNext == '0);
      oFull  <= (countNext == CNT_FULL);
      // A dropped push outranks a same-cycle clear so no loss goes unreported.
      if (iPush && oFull) oOverflow <= 1'b1;
      else if (iClrOvf)   oOverflow <= 1'b0;
    end
  end

  // oTX is loaded with the level of the state being entered, so it is always registered.
  always_ff @(posedge iSClk or posedge iRst) begin
    if (iRst) begin
      state    <= IDLE;
      oTX      <= 1'b1;
      oBusy    <= 1'b0;
      oDone    <= 1'b0;
      osCnt    <= '0;
      bitCnt   <= '0;
      shiftReg <= '0;
      stop2    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parBit   <= 1'b0;
`endif
    end else begin
      oDone <= 1'b0;
      if (pop) begin
        shiftReg <= headByte;
        stop2    <= iStopBits;
`ifdef UART_TX_PARITY_EN
        parBit   <= (^headByte) ^ iParityOdd;
`endif
        state    <= START;
        oBusy    <= 1'b1;
        oTX      <= 1'b0;
        osCnt    <= '0;
        bitCnt   <= '0;
        oDone    <= frameEnd;
      end else if (state != IDLE) begin
        if (!osEnd) begin
          osCnt <= osCnt + OS_ONE;
        end else begin
          osCnt <= '0;
          case (state)
            START: begin
              state <= DATA;
              oTX   <= shiftReg[0];
            end
            DATA: begin
              if (bitCnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                state <= PARITY;
                oTX   <= parBit;
`else
                state <= STOP1;
                oTX   <= 1'b1;
`endif
              end else begin
                shiftReg <= {1'b0, shiftReg[7:1]};
                oTX      <= shiftReg[1];
                bitCnt   <= bitCnt + 3'd1;
              end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
              state <= STOP1;
              oTX   <= 1'b1;
            end
`endif
            STOP1: begin
              oTX <= 1'b1;
              if (stop2) begin
                state <= STOP2;
              end else begin
                state <= IDLE;
                oBusy <= 1'b0;
                oDone <= 1'b1;
              end
            end
            STOP2: begin
              state <= IDLE;
              oBusy <= 1'b0;
              oDone <= 1'b1;
              oTX   <= 1'b1;
            end
            default: begin
              state <= IDLE;
              oBusy <= 1'b0;
              oTX   <= 1'b1;
            end
          endcase
        end
      end
    end
  end

endmodule
